// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a sweep engine that fills every word with INIT_VALUE.
module ram_sdp_be_clr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter int                    RD_LATENCY = 1,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int                    NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state <= CLEAR;
        ptr   <= '0;
      end
    end else begin
      if (ptr == LAST_ADDR) state <= IDLE;
      ptr <= ptr + ADDR_WIDTH'(1);
    end
  end

  assign busy = (state == CLEAR);

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NUM_BYTES-1:0]  mem_be;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rdw_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_v1;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // The sweep owns the write port; user traffic is only taken while idle.
  assign mem_we   = !rst && (busy || (wr_en && wr_in_range));
  assign mem_addr = busy ? ptr : wr_addr;
  assign mem_data = busy ? INIT_VALUE : wr_data;
  assign mem_be   = busy ? '1 : wr_be;
  assign rd_fire  = !rst && !busy && rd_en;
  assign rd_idx   = rd_in_range ? rd_addr : '0;
  assign rdw_hit  = (RDW_MODE == 1) && mem_we && (mem_addr == rd_addr);

  // One RAM per byte lane keeps byte-enable writes a plain per-lane write enable.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [7:0] lane [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (mem_we && mem_be[gi]) lane[mem_addr] <= mem_data[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (rd_fire) begin
        if (!rd_in_range)              lane_q <= '0;
        else if (rdw_hit && mem_be[gi]) lane_q <= mem_data[8*gi +: 8];
        else                            lane_q <= lane[rd_idx];
      end
    end

    assign rd_word[8*gi +: 8] = lane_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_v1 <= 1'b0;
    else     rd_v1 <= rd_fire;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = rd_word;
    assign rd_valid = rd_v1;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_d2;
    logic                  rd_v2;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_d2 <= '0;
        rd_v2 <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_word;
      end
    end

    assign rd_data  = rd_d2;
    assign rd_valid = rd_v2;
  end

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Drives two RAM instances (latency 2 / old-data and latency 1 / new-data) with one
// stimulus stream and compares both against an array-and-queue reference model.
module tb_ram_sdp_be_clr;

  localparam int          DEPTH = 1000;
  localparam logic [31:0] INIT  = 32'hC0DE_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  always #5 clk = ~clk;

  ram_sdp_be_clr #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RD_LATENCY(2), .RDW_MODE(0), .INIT_VALUE(INIT)) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  ram_sdp_be_clr #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(1), .INIT_VALUE(INIT)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  typedef struct { int due; logic [31:0] d; } rd_t;

  logic [31:0] mem_m [DEPTH];
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  int          clr_left = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Model one clock edge from the current inputs, then check both instances.
  task automatic tick();
    logic [31:0] old_w, new_w;
    rd_t e;
    cyc++;
    if (rst) begin
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (rd_en) begin
        old_w = '0; new_w = '0;
        if (rd_addr < DEPTH) begin
          old_w = mem_m[rd_addr];
          new_w = old_w;
          if (wr_en && wr_addr == rd_addr)
            for (int b = 0; b < 4; b++) if (wr_be[b]) new_w[8*b +: 8] = wr_data[8*b +: 8];
        end
        e.due = cyc + 1; e.d = old_w; qa.push_back(e);
        e.due = cyc;     e.d = new_w; qb.push_back(e);
      end
      if (wr_en && wr_addr < DEPTH)
        for (int b = 0; b < 4; b++) if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (clr_req) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
      end
    end
    @(posedge clk); #1;
    chk("busy_a", {31'b0, busy_a}, {31'b0, clr_left > 0});
    chk("busy_b", {31'b0, busy_b}, {31'b0, clr_left > 0});
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("valid_a", {31'b0, rd_valid_a}, 32'd1);
      chk("data_a", rd_data_a, qa[0].d);
      last_a = qa[0].d;
      void'(qa.pop_front());
    end else begin
      chk("valid_a", {31'b0, rd_valid_a}, 32'd0);
      chk("hold_a", rd_data_a, last_a);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("valid_b", {31'b0, rd_valid_b}, 32'd1);
      chk("data_b", rd_data_b, qb[0].d);
      last_b = qb[0].d;
      void'(qb.pop_front());
    end else begin
      chk("valid_b", {31'b0, rd_valid_b}, 32'd0);
      chk("hold_b", rd_data_b, last_b);
    end
  endtask

  task automatic step(input logic we, input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input logic [9:0] ra, input logic clr, input logic r);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = clr; rst = r;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) step(0, 0, 0, 0, 1, 10'(a), 0, 0);
    idle(3);
  endtask

  task automatic wait_sweep();
    while (clr_left > 0) idle(1);
  endtask

  initial begin
    // Reset, full sweep, then every word reads back as INIT.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    wait_sweep();
    idle(2);
    read_range(0, DEPTH - 1);

    // Full write then single-byte overwrite; read-back gives the merged word.
    step(1, 10'd5, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd5, 32'h0000AA00, 4'b0010, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10'd5, 0, 0);
    step(1, 10'd6, 32'h12345678, 4'b0000, 0, 0, 0, 0);
    read_range(5, 6);

    // Same-address write and read in one cycle.
    step(1, 10'd7, 32'h22222222, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd7, 32'h11111111, 4'b1111, 1, 10'd7, 0, 0);
    step(1, 10'd8, 32'h33333333, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd8, 32'hAABBCCDD, 4'b0101, 1, 10'd8, 0, 0);
    read_range(7, 8);

    // Clear request with a read issued the cycle before; traffic held high during the sweep.
    step(1, 10'd9, 32'h99999999, 4'b1111, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10'd9, 0, 0);
    step(0, 0, 0, 0, 1, 10'd8, 1, 0);
    for (int i = 0; i < DEPTH + 5; i++)
      step(1, 10'($urandom_range(0, 15)), $urandom, 4'($urandom), 1, 10'($urandom_range(0, 15)), i == 9, 0);
    read_range(0, 15);

    // Reset with a read in flight, then reset again 100 cycles into the sweep.
    step(1, 10'd3, 32'h0BADF00D, 4'b1111, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10'd3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 99; i++) step(1, 10'd4, $urandom, 4'hF, 1, 10'd4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    wait_sweep();
    idle(2);

    // Out-of-range write and read, then back-to-back reads.
    step(1, 10'd0, 32'h00000A0A, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd1, 32'h00000B0B, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd1010, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0);
    step(1, 10'd1010, 32'hEEEEEEEE, 4'b1111, 1, 10'd1010, 0, 0);
    step(0, 0, 0, 0, 1, 10'd1010, 0, 0);
    read_range(0, 3);
    read_range(DEPTH - 24, DEPTH - 1);

    // Randomised traffic with occasional clear requests.
    for (int i = 0; i < 800; i++) begin
      logic [9:0] wa, ra;
      wa = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(DEPTH, 1023)) : 10'($urandom_range(0, 19));
      ra = ($urandom_range(0, 1) == 0) ? wa : 10'($urandom_range(0, 19));
      step(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra, $urandom_range(0, 399) == 0, 0);
    end
    wait_sweep();
    idle(2);
    read_range(0, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
